// File: rtl/operand_stage.sv
// operand_stage
//   ID/EX operand stage for the RV32I core. Selects ALU operands A/B by opcode,
//   resolves rs1/rs2 forwarding from NUM_FWD later stages (index 0 youngest,
//   highest priority), stalls on load-use hazards and registers the result in
//   a valid/ready pipeline register with flush.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           decode handshake
//   in_pc, in_opcode, in_imm      instruction fields from decode
//   in_rs1_addr/data, in_rs2_*    source indices and register-file data
//   fwd_valid, fwd_is_load        per-source write in flight / load pending
//   fwd_rd, fwd_data              packed per-source destination and result
//   flush                         kill registered and incoming instruction
//   out_valid / out_ready         execute handshake
//   out_operand_a/b, out_store_data, out_pc, out_opcode   registered outputs
//   stall_cycles                  saturating hazard-stall cycle count
module operand_stage #(
  parameter int XLEN        = 32,
  parameter int NUM_FWD     = 2,
  parameter int STALL_CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [6:0]               in_opcode,
  input  logic [4:0]               in_rs1_addr,
  input  logic [4:0]               in_rs2_addr,
  input  logic [XLEN-1:0]          in_rs1_data,
  input  logic [XLEN-1:0]          in_rs2_data,
  input  logic [XLEN-1:0]          in_imm,
  input  logic [NUM_FWD-1:0]       fwd_valid,
  input  logic [NUM_FWD-1:0]       fwd_is_load,
  input  logic [5*NUM_FWD-1:0]     fwd_rd,
  input  logic [XLEN*NUM_FWD-1:0]  fwd_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_operand_a,
  output logic [XLEN-1:0]          out_operand_b,
  output logic [XLEN-1:0]          out_store_data,
  output logic [XLEN-1:0]          out_pc,
  output logic [6:0]               out_opcode,
  output logic [STALL_CNT_W-1:0]   stall_cycles
);

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic            rs1_load, rs2_load;
  logic            use_rs1, use_rs2;
  logic            hazard;
  logic [XLEN-1:0] operand_a, operand_b;

  // Walk from the oldest source to the youngest so the lowest matching index
  // is the last writer and therefore wins. x0 never matches.
  always_comb begin
    rs1_fwd  = in_rs1_data;
    rs2_fwd  = in_rs2_data;
    rs1_load = 1'b0;
    rs2_load = 1'b0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (in_rs1_addr != 5'd0 && fwd_valid[i] && fwd_rd[i*5 +: 5] == in_rs1_addr) begin
        rs1_fwd  = fwd_data[i*XLEN +: XLEN];
        rs1_load = fwd_is_load[i];
      end
      if (in_rs2_addr != 5'd0 && fwd_valid[i] && fwd_rd[i*5 +: 5] == in_rs2_addr) begin
        rs2_fwd  = fwd_data[i*XLEN +: XLEN];
        rs2_load = fwd_is_load[i];
      end
    end
    if (in_rs1_addr == 5'd0) rs1_fwd = '0;
    if (in_rs2_addr == 5'd0) rs2_fwd = '0;
  end

  always_comb begin
    use_rs1 = !(in_opcode == OPCODE_JAL || in_opcode == OPCODE_LUI ||
                in_opcode == OPCODE_AUIPC);
    use_rs2 = (in_opcode == OPCODE_OP || in_opcode == OPCODE_BRANCH ||
               in_opcode == OPCODE_STORE);
    hazard  = in_valid && ((use_rs1 && rs1_load) || (use_rs2 && rs2_load));
  end

  always_comb begin
    operand_a = rs1_fwd;
    if (in_opcode == OPCODE_JAL || in_opcode == OPCODE_AUIPC) operand_a = in_pc;
    else if (in_opcode == OPCODE_LUI)                         operand_a = '0;
    operand_b = in_imm;
    if (in_opcode == OPCODE_OP || in_opcode == OPCODE_BRANCH) operand_b = rs2_fwd;
  end

  // Flush forces ready so decode can drop its instruction in the same cycle.
  assign in_ready = flush || (!hazard && (!out_valid || out_ready));

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_operand_a  <= '0;
      out_operand_b  <= '0;
      out_store_data <= '0;
      out_pc         <= '0;
      out_opcode     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid      <= 1'b1;
      out_operand_a  <= operand_a;
      out_operand_b  <= operand_b;
      out_store_data <= rs2_fwd;
      out_pc         <= in_pc;
      out_opcode     <= in_opcode;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (hazard && !flush && stall_cycles != {STALL_CNT_W{1'b1}}) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: doc/operand_stage.md
# operand_stage

Parametrised ID/EX operand stage for the RV32I core. It replaces the purely combinational operand-A mux. It selects ALU operands A and B per opcode and resolves register-source forwarding from NUM_FWD later pipeline stages. It stalls on load-use hazards and registers the result into a valid/ready pipeline register with flush. It sits between the register file/immediate generator (decode) and the ALU (execute).

## Interface
- XLEN, 32, datapath width
- NUM_FWD, 2, number of forwarding sources; index 0 = youngest stage (highest priority)
- STALL_CNT_W, 16, width of the saturating stall counter

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_pc  in  XLEN  instruction PC
- in_opcode  in  7  opcode, riscv_pkg OPCODE_* encodings
- in_rs1_addr, in_rs2_addr  in  5 each  source register indices
- in_rs1_data, in_rs2_data  in  XLEN each  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- fwd_valid  in  NUM_FWD  source i holds a register write in flight
- fwd_is_load  in  NUM_FWD  source i data is not yet available (load in flight)
- fwd_rd  in  5*NUM_FWD  destination register of source i
- fwd_data  in  XLEN*NUM_FWD  result of source i
- flush  in  1  kill the registered and incoming instruction
- out_valid  out  1  registered instruction valid
- out_ready  in  1  execute accepts
- out_operand_a, out_operand_b, out_store_data, out_pc  out  XLEN each  registered operands, store data, PC
- out_opcode  out  7  registered opcode
- stall_cycles  out  STALL_CNT_W  saturating count of hazard-stall cycles

## Operation
- Forwarded rsN value: if rsN_addr == 0, the value is 0 and no source can match. Otherwise the lowest index i with fwd_valid[i] && fwd_rd[i] == rsN_addr supplies fwd_data[i]. With no match, in_rsN_data is used.
- Hazard: in_valid, a used source, and a highest-priority match with fwd_is_load[i] = 1. A lower-priority load match shadowed by a higher non-load match is not a hazard.
- Used sources: rs1 for all opcodes except JAL, LUI and AUIPC. rs2 for OP, BRANCH and STORE.
- Operand A: JAL and AUIPC select in_pc. LUI selects 0. JALR and all others select forwarded rs1.
- Operand B: OP and BRANCH select forwarded rs2. All others select in_imm.
- out_store_data is always forwarded rs2.
- in_ready = flush || (!hazard && (!out_valid || out_ready)).
- Register update, in priority order:
  - rst: everything is cleared.
  - flush: out_valid is set to 0 and the input is discarded.
  - Otherwise, if in_valid && in_ready: the register loads and out_valid is set to 1.
  - Otherwise, if out_ready: out_valid is set to 0.
  - Otherwise the register holds.
- stall_cycles increments on every cycle with hazard && !flush && !rst. It saturates at all-ones and is cleared only by rst.

## Timing
- Reset values: out_valid = 0; out_operand_a, out_operand_b, out_store_data, out_pc = 0; out_opcode = 0; stall_cycles = 0.
- Latency is 1 cycle from accept (in_valid && in_ready) to out_valid.
- Sustained throughput is 1 instruction per cycle while out_ready = 1 and there is no hazard.
- Backpressure: while out_valid && !out_ready, all out_* outputs stay stable and in_ready = 0.
- in_ready is combinational from hazard, out_valid, out_ready and flush.
- Forwarding and hazard evaluation use inputs sampled in the accept cycle.
- A hazard lasts as long as fwd_is_load stays asserted. Decode holds its inputs; the stage holds its output register.
- Simultaneous flush and hazard: flush wins, and the stall counter does not increment.
- rst mid-stall or mid-backpressure: the outputs return to reset values on the next edge.

## Test plan
- AUIPC, pc=0x100, imm=0x2000 -> out_operand_a=0x100, out_operand_b=0x2000, out_valid=1 one cycle after accept.
- LUI, imm=0xABCDE000 -> out_operand_a=0, out_operand_b=0xABCDE000.
- JAL, pc=0x40 -> out_operand_a=0x40. JALR, rs1=x5 with regfile value 0x10 -> out_operand_a=0x10.
- OP with rs1=x3, rs2=x3; fwd0 rd=x3 data=0x11; fwd1 rd=x3 data=0x22 -> out_operand_a=0x11, out_operand_b=0x11.
- rs1=x0 with fwd0 rd=x0 data=0xFF -> out_operand_a=0.
- Load-use: fwd0 rd=x7 is_load=1 for 3 cycles, next instruction OP with rs1=x7 -> in_ready=0 for 3 cycles and stall_cycles=3. When is_load drops with data=0x5, the instruction is accepted with out_operand_a=0x5.
- Backpressure: out_ready=0 for 2 cycles with out_valid=1 -> outputs are stable and in_ready=0.
- Flush during backpressure -> out_valid=0 on the next cycle and the incoming instruction is dropped.
